// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants for the two-port data memory arbiter: state encoding and port indices.
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/data_mem_rr_pick.sv
// Combinational grant selection between two requesters: fixed priority or
// round-robin against the last granted port.
module data_mem_rr_pick
  import data_mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic fixed_pri,
  output logic grant_valid,
  output logic grant_idx
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = P0;
    if (req0 && req1) begin
      grant_idx = fixed_pri ? P0 : ~last;
    end else if (req1) begin
      grant_idx = P1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port word memory: one access
// cycle per grant, captured read data and a one-cycle ack/err response.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 256,
  parameter int FIXED_PRI = 0
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iReq0,
  input  logic              iReq1,
  input  logic              iWe0,
  input  logic              iWe1,
  input  logic [ADDR_W-1:0] iAddr0,
  input  logic [ADDR_W-1:0] iAddr1,
  input  logic [DATA_W-1:0] iWdata0,
  input  logic [DATA_W-1:0] iWdata1,
  output logic              oAck0,
  output logic              oAck1,
  output logic [DATA_W-1:0] oRdata0,
  output logic [DATA_W-1:0] oRdata1,
  output logic              oErr0,
  output logic              oErr1,
  output logic [ADDR_W-1:0] oMemEnd,
  output logic [DATA_W-1:0] oMemDado,
  output logic              oMemEsc,
  output logic              oMemLe,
  input  logic [DATA_W-1:0] iMemDado,
  output logic              oBusy
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  state_e            state_q, state_d;
  logic              winner_q, winner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              pick_req0, pick_req1, grant_valid, grant_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH_A);
  endfunction

  // In RESP the acked port still shows its old request; only the other port may chain.
  always_comb begin
    pick_req0 = iReq0;
    pick_req1 = iReq1;
    if (state_q == RESP) begin
      if (winner_q == P0) pick_req0 = 1'b0;
      else                pick_req1 = 1'b0;
    end
  end

  data_mem_rr_pick u_pick (
    .req0        (pick_req0),
    .req1        (pick_req1),
    .last        (last_q),
    .fixed_pri   (FIXED_PRI != 0),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign sel_we    = grant_idx ? iWe1    : iWe0;
  assign sel_addr  = grant_idx ? iAddr1  : iAddr0;
  assign sel_wdata = grant_idx ? iWdata1 : iWdata0;

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    last_d   = last_q;
    we_d     = we_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (grant_valid) begin
          state_d  = ACCESS;
          winner_d = grant_idx;
          we_d     = sel_we;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          err_d    = addr_bad(sel_addr);
        end
      end
      ACCESS: begin
        state_d = RESP;
        last_d  = winner_q;
        if (!we_q) begin
          if (winner_q == P0) rdata0_d = err_q ? '0 : iMemDado;
          else                rdata1_d = err_q ? '0 : iMemDado;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q  <= IDLE;
      winner_q <= P0;
      last_q   <= P1;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Address/data lines come straight from the capture registers, so they hold between accesses.
  assign oMemEnd  = addr_q;
  assign oMemDado = wdata_q;
  assign oMemEsc  = (state_q == ACCESS) &&  we_q && !err_q;
  assign oMemLe   = (state_q == ACCESS) && !we_q && !err_q;

  assign oAck0   = (state_q == RESP) && (winner_q == P0);
  assign oAck1   = (state_q == RESP) && (winner_q == P1);
  assign oErr0   = oAck0 && err_q;
  assign oErr1   = oAck1 && err_q;
  assign oRdata0 = rdata0_q;
  assign oRdata1 = rdata1_q;
  assign oBusy   = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench: round-robin instance with a memory model and ack scoreboard,
// plus a fixed-priority instance for the tie-break corner.
module tb_data_mem_arbiter;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    logic        port;
    logic        err;
    logic        chk_rd;
    logic [31:0] rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        ack0, ack1, err0, err1, mem_esc, mem_le, busy;
  logic [31:0] rd0, rd1, mem_end, mem_dado, mem_rd;

  logic        f_req0 = 0, f_req1 = 0;
  logic [31:0] f_addr0 = 0, f_addr1 = 0;
  logic        f_ack0, f_ack1, f_err0, f_err1, f_esc, f_le, f_busy;
  logic [31:0] f_rd0, f_rd1, f_end, f_dado, f_mem_rd;

  logic [31:0] mem [256];
  logic        mem_inited = 1'b0;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[14];

  always #5 clk = ~clk;

  data_mem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .FIXED_PRI(0)) u_dut (
    .iCLK(clk), .iRST_n(rst_n),
    .iReq0(req0), .iReq1(req1), .iWe0(we0), .iWe1(we1),
    .iAddr0(addr0), .iAddr1(addr1), .iWdata0(wdata0), .iWdata1(wdata1),
    .oAck0(ack0), .oAck1(ack1), .oRdata0(rd0), .oRdata1(rd1),
    .oErr0(err0), .oErr1(err1),
    .oMemEnd(mem_end), .oMemDado(mem_dado), .oMemEsc(mem_esc), .oMemLe(mem_le),
    .iMemDado(mem_rd), .oBusy(busy)
  );

  data_mem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .FIXED_PRI(1)) u_fx (
    .iCLK(clk), .iRST_n(rst_n),
    .iReq0(f_req0), .iReq1(f_req1), .iWe0(1'b0), .iWe1(1'b0),
    .iAddr0(f_addr0), .iAddr1(f_addr1), .iWdata0(32'h0), .iWdata1(32'h0),
    .oAck0(f_ack0), .oAck1(f_ack1), .oRdata0(f_rd0), .oRdata1(f_rd1),
    .oErr0(f_err0), .oErr1(f_err1),
    .oMemEnd(f_end), .oMemDado(f_dado), .oMemEsc(f_esc), .oMemLe(f_le),
    .iMemDado(f_mem_rd), .oBusy(f_busy)
  );

  // Memory model: combinational read, write on the rising edge.
  assign mem_rd   = mem[mem_end[9:2]];
  assign f_mem_rd = f_end ^ 32'h5A5A_5A5A;

  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | i;
      mem_inited <= 1'b1;
    end else if (mem_esc) begin
      mem[mem_end[9:2]] <= mem_dado;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("mem_en_excl", {31'b0, mem_esc & mem_le}, 32'h0);
      chk("ack_excl", {31'b0, ack0 & ack1}, 32'h0);
      chk("fx_en_excl", {31'b0, f_esc | f_le | f_dado[0] & 1'b0 ? f_esc & f_le : 1'b0}, 32'h0);
      if (ack0 || ack1) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'h1, 32'h0);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_port", {31'b0, ack1}, {31'b0, mon_e.port});
          chk("ack_err", {31'b0, ack1 ? err1 : err0}, {31'b0, mon_e.err});
          if (mon_e.chk_rd) chk("ack_rdata", ack1 ? rd1 : rd0, mon_e.rd);
        end
      end
    end
  end

  task automatic do_acc(input vec_t v);
    exp_t e;
    @(negedge clk);
    if (v.port) begin req1 = 1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; end
    else        begin req0 = 1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; end
    e = '{v.port, v.exp_err, !v.we, v.exp_rd};
    sb.push_back(e);
    @(negedge clk);
    chk("acc_esc", {31'b0, mem_esc}, {31'b0, v.we & ~v.exp_err});
    chk("acc_le", {31'b0, mem_le}, {31'b0, ~v.we & ~v.exp_err});
    chk("acc_end", mem_end, v.addr);
    if (v.we) chk("acc_dado", mem_dado, v.wdata);
    // Fields changed after capture must not affect the access in flight.
    if (v.port) begin addr1 = v.addr ^ 32'h4; wdata1 = ~v.wdata; we1 = ~v.we; end
    else        begin addr0 = v.addr ^ 32'h4; wdata0 = ~v.wdata; we0 = ~v.we; end
    @(negedge clk);
    chk("ack_latency", {31'b0, v.port ? ack1 : ack0}, 32'h1);
    req0 = 0; req1 = 0;
  endtask

  // Both ports read continuously; expect strict alternation with 2-cycle ack spacing.
  task automatic tie_run(input logic first);
    int   cyc, nack, last_ack;
    exp_t e;
    logic p;
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 32'h10;
    req1 = 1; we1 = 0; addr1 = 32'h3FC;
    p = first;
    for (int k = 0; k < 4; k++) begin
      e = '{p, 1'b0, 1'b1, p ? 32'h1234_5678 : 32'hDEAD_BEEF};
      sb.push_back(e);
      p = ~p;
    end
    cyc = 0; nack = 0; last_ack = 0;
    while (nack < 4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) begin
        nack++;
        chk("tie_ack_gap", cyc - last_ack, 32'd2);
        last_ack = cyc;
        if (nack == 4) begin req0 = 0; req1 = 0; end
      end
    end
    req0 = 0; req1 = 0;
    chk("tie_ack_count", nack, 32'd4);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h10,  32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 1'b1, 32'h3FC, 32'h1234_5678, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h3FC, 32'h0,         1'b0, 32'h1234_5678};
    vecs[4]  = '{1'b0, 1'b1, 32'h20,  32'h1111_1111, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 32'h13,  32'hBAD0_BAD0, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h13,  32'h0,         1'b1, 32'h0};
    vecs[7]  = '{1'b1, 1'b1, 32'h400, 32'hBAD1_BAD1, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'h20,  32'h0,         1'b0, 32'h1111_1111};
    vecs[9]  = '{1'b1, 1'b0, 32'h400, 32'h0,         1'b1, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h3FC, 32'h0,         1'b0, 32'h1234_5678};
    vecs[11] = '{1'b0, 1'b1, 32'h1,   32'hBAD2_BAD2, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'h10,  32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[13] = '{1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 32'hC0DE_0000};

    repeat (3) @(negedge clk);
    chk("rst_ack", {30'b0, ack0, ack1}, 32'h0);
    chk("rst_err", {30'b0, err0, err1}, 32'h0);
    chk("rst_en", {29'b0, mem_esc, mem_le, busy}, 32'h0);
    chk("rst_end", mem_end, 32'h0);
    chk("rst_dado", mem_dado, 32'h0);
    chk("rst_rd0", rd0, 32'h0);
    chk("rst_rd1", rd1, 32'h0);
    rst_n = 1'b1;

    // Fixed priority: after a port-0 grant, an IDLE tie still goes to port 0.
    @(negedge clk);
    f_req0 = 1; f_addr0 = 32'h40;
    repeat (2) @(negedge clk);
    chk("fx_solo_ack0", {30'b0, f_ack0, f_ack1}, 32'h2);
    chk("fx_solo_rd0", f_rd0, 32'h40 ^ 32'h5A5A_5A5A);
    f_req0 = 0;
    @(negedge clk);
    f_req0 = 1; f_addr0 = 32'h44; f_req1 = 1; f_addr1 = 32'h48;
    repeat (2) @(negedge clk);
    chk("fx_tie_ack0", {30'b0, f_ack0, f_ack1}, 32'h2);
    chk("fx_tie_rd0", f_rd0, 32'h44 ^ 32'h5A5A_5A5A);
    repeat (2) @(negedge clk);
    chk("fx_chain_ack1", {30'b0, f_ack0, f_ack1}, 32'h1);
    chk("fx_chain_rd1", f_rd1, 32'h48 ^ 32'h5A5A_5A5A);
    chk("fx_err", {30'b0, f_err0, f_err1}, 32'h0);
    f_req0 = 0; f_req1 = 0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) do_acc(vecs[i]);
    chk("mem_word0_kept", mem[0], 32'hC0DE_0000);
    chk("mem_word4", mem[4], 32'hDEAD_BEEF);

    // Reset during the access cycle of a write to 0x20.
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h2222_2222;
    @(posedge clk);
    #1;
    chk("rst_mid_esc_pre", {31'b0, mem_esc}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_esc", {30'b0, mem_esc, mem_le}, 32'h0);
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    chk("rst_mid_end", mem_end, 32'h0);
    chk("rst_mid_rd", rd0 | rd1, 32'h0);
    req0 = 0; we0 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_no_write", mem[8], 32'h1111_1111);
    chk("rst_idle", {31'b0, busy}, 32'h0);

    tie_run(1'b0);
    do_acc(vecs[1]);
    tie_run(1'b1);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
